// File: rtl/e203_ifu_bht_2bc.sv
// e203_ifu_bht_2bc: 2-bit saturating-counter BHT with sweep init and a bypassed 2-stage update pipe.
// Optional gshare indexing is enabled by defining E203_BHT_GSHARE_EN.
`default_nettype none

module e203_ifu_bht_2bc #(
  parameter int PC_SIZE = 32,
  parameter int IDX_W   = 7,
  parameter int GHR_W   = 7
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_valid,
  input  logic [PC_SIZE-1:0] io_pc,
  output logic               io_takenPre,
  output logic               io_ready,
  input  logic               io_takenValid,
  input  logic               io_takenMiss,
  input  logic               io_exTakenPre,
  input  logic [PC_SIZE-1:0] io_takenPC,
  output logic [15:0]        bht_mis_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sweep_ptr_q;
  logic             ready_q;

  logic [1:0]       ctr_q [DEPTH];

  logic             upd_vld_q, upd_vld_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_dir_q, upd_dir_d;
  logic [15:0]      mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0] w_hist;
  logic [IDX_W-1:0] w_q_idx;
  logic [IDX_W-1:0] w_u_idx;
  logic             w_accept;
  logic [1:0]       w_old;
  logic [1:0]       w_new;
  logic [1:0]       w_cval;
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic [1:0]       w_wdata;

  assign w_accept = io_takenValid & ready_q;

`ifdef E203_BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (w_accept) begin
      ghr_q <= {ghr_q[GHR_W-2:0], io_exTakenPre};
    end
  end

  assign w_hist = IDX_W'(ghr_q);
`else
  logic unused_ghr_w;
  assign unused_ghr_w = (GHR_W > IDX_W);
  assign w_hist       = '0;
`endif

  assign w_q_idx = io_pc[IDX_W:1] ^ w_hist;
  assign w_u_idx = io_takenPC[IDX_W:1] ^ w_hist;

  // Sweep FSM: one entry per cycle, ready raised the cycle after the last entry is written.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      sweep_ptr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          sweep_ptr_q <= sweep_ptr_q + 1'b1;
          if (sweep_ptr_q == '1) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          sweep_ptr_q <= '0;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    upd_vld_d = w_accept;
    upd_idx_d = upd_idx_q;
    upd_dir_d = upd_dir_q;
    mis_cnt_d = mis_cnt_q;
    if (w_accept) begin
      upd_idx_d = w_u_idx;
      upd_dir_d = io_exTakenPre;
      if (io_takenMiss) begin
        mis_cnt_d = mis_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      upd_vld_q <= 1'b0;
      upd_idx_q <= '0;
      upd_dir_q <= 1'b0;
      mis_cnt_q <= '0;
    end else begin
      upd_vld_q <= upd_vld_d;
      upd_idx_q <= upd_idx_d;
      upd_dir_q <= upd_dir_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign w_old = ctr_q[upd_idx_q];

  always_comb begin
    w_new = w_old;
    if (upd_dir_q) begin
      if (w_old != 2'b11) w_new = w_old + 2'd1;
    end else begin
      if (w_old != 2'b00) w_new = w_old - 2'd1;
    end
  end

  // Sweep and training never overlap: captures need ready, which only rises in RUN.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = upd_idx_q;
    w_wdata = w_new;
    if (state_q == ST_INIT) begin
      w_we    = 1'b1;
      w_widx  = sweep_ptr_q;
      w_wdata = 2'b01;
    end else if (upd_vld_q) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      ctr_q[w_widx] <= w_wdata;
    end
  end

  assign w_cval = (upd_vld_q && (upd_idx_q == w_q_idx)) ? w_new : ctr_q[w_q_idx];

  assign io_takenPre = io_valid & ready_q & w_cval[1];
  assign io_ready    = ready_q;
  assign bht_mis_cnt = mis_cnt_q;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{io_pc[PC_SIZE-1:IDX_W+1], io_pc[0],
                            io_takenPC[PC_SIZE-1:IDX_W+1], io_takenPC[0]};

endmodule

`default_nettype wire

// File: tb/tb_e203_ifu_bht_2bc.sv
// Bench for e203_ifu_bht_2bc: per-cycle comparison against a direction-table model plus literal checks.
`default_nettype none

module tb_e203_ifu_bht_2bc;

  logic        clock;
  logic        reset;
  logic        io_valid;
  logic [31:0] io_pc;
  logic        io_takenPre;
  logic        io_ready;
  logic        io_takenValid;
  logic        io_takenMiss;
  logic        io_exTakenPre;
  logic [31:0] io_takenPC;
  logic [15:0] bht_mis_cnt;

  e203_ifu_bht_2bc dut (
    .clock         (clock),
    .reset         (reset),
    .io_valid      (io_valid),
    .io_pc         (io_pc),
    .io_takenPre   (io_takenPre),
    .io_ready      (io_ready),
    .io_takenValid (io_takenValid),
    .io_takenMiss  (io_takenMiss),
    .io_exTakenPre (io_exTakenPre),
    .io_takenPC    (io_takenPC),
    .bht_mis_cnt   (bht_mis_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: counters change as soon as an update is accepted, since the bypass hides the write latency.
  int m_ctr [128];
  int m_cnt;
  bit m_ready;
  int m_mis;
  bit chk_en = 1'b0;

  localparam logic [31:0] PC_A = 32'h8000_0010;
  localparam logic [31:0] PC_B = 32'h8000_0014;
  localparam logic [31:0] PC_C = 32'h8000_0020;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd2) % 32'd128);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_ctr[i] = 1;
    m_cnt   = 0;
    m_ready = 1'b0;
    m_mis   = 0;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else begin
      if (m_ready && io_takenValid) begin
        int i;
        i = idx_of(io_takenPC);
        if (io_exTakenPre) m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
        else               m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
        if (io_takenMiss) m_mis = (m_mis + 1) % 65536;
      end
      m_cnt++;
      if (m_cnt >= 128) m_ready = 1'b1;
    end
  endtask

  function automatic logic exp_pred();
    return io_valid && m_ready && (m_ctr[idx_of(io_pc)] >= 2);
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      chk("ready", {31'd0, io_ready}, {31'd0, m_ready});
      chk("pred", {31'd0, io_takenPre}, {31'd0, exp_pred()});
      chk("miscnt", {16'd0, bht_mis_cnt}, m_mis[31:0]);
    end
  end

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    model_reset();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = -1;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (io_ready) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic dir, input logic miss);
    io_takenValid = 1'b1;
    io_takenPC    = pc;
    io_exTakenPre = dir;
    io_takenMiss  = miss;
    tick();
    io_takenValid = 1'b0;
    io_takenMiss  = 1'b0;
  endtask

  task automatic query(input logic [31:0] pc);
    io_valid = 1'b1;
    io_pc    = pc;
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        dir;
    logic        miss;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int n;
    reset         = 1'b1;
    io_valid      = 1'b0;
    io_pc         = '0;
    io_takenValid = 1'b0;
    io_takenMiss  = 1'b0;
    io_exTakenPre = 1'b0;
    io_takenPC    = '0;
    model_reset();
    chk_en = 1'b1;

    vecs[0] = '{32'h8000_0040, 1'b1, 1'b1};
    vecs[1] = '{32'h8000_0040, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0042, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0140, 1'b1, 1'b1};
    vecs[4] = '{32'h8000_0042, 1'b0, 1'b1};
    vecs[5] = '{32'h8000_00fe, 1'b1, 1'b0};
    vecs[6] = '{32'h8000_00fe, 1'b1, 1'b0};
    vecs[7] = '{32'h8000_0040, 1'b0, 1'b0};

    repeat (2) tick();
    io_valid = 1'b1;
    io_pc    = PC_A;
    #1;
    chk("rst_ready", {31'd0, io_ready}, 32'd0);
    chk("rst_pred", {31'd0, io_takenPre}, 32'd0);
    chk("rst_mis", {16'd0, bht_mis_cnt}, 32'd0);
    reset = 1'b0;

    wait_ready(n);
    chk("init_len", n, 32'd128);
    query(PC_A);
    chk("init_pred", {31'd0, io_takenPre}, 32'd0);

    upd(PC_A, 1'b1, 1'b0);
    tick();
    query(PC_A);
    chk("taken1_pred", {31'd0, io_takenPre}, 32'd1);
    upd(PC_A, 1'b1, 1'b0);
    tick();
    query(PC_A);
    chk("taken2_pred", {31'd0, io_takenPre}, 32'd1);

    repeat (4) upd(PC_A, 1'b0, 1'b0);
    tick();
    query(PC_A);
    chk("sat0_pred", {31'd0, io_takenPre}, 32'd0);
    upd(PC_A, 1'b1, 1'b0);
    tick();
    query(PC_A);
    chk("from0_pred", {31'd0, io_takenPre}, 32'd0);

    upd(PC_A, 1'b1, 1'b0);
    query(PC_A);
    chk("bypass_pred", {31'd0, io_takenPre}, 32'd1);
    tick();
    upd(PC_C, 1'b1, 1'b0);
    query(PC_B);
    chk("indep_pred", {31'd0, io_takenPre}, 32'd0);
    tick();

    upd(PC_A, 1'b1, 1'b0);
    upd(PC_A, 1'b1, 1'b0);
    tick();
    query(32'h8000_0110);
    chk("alias_pred", {31'd0, io_takenPre}, 32'd1);
    query(32'h8000_0012);
    chk("rvc_pred", {31'd0, io_takenPre}, 32'd0);

    repeat (3) upd(PC_A, 1'b0, 1'b1);
    io_takenMiss = 1'b1;
    tick();
    io_takenMiss = 1'b0;
    chk("mis3", {16'd0, bht_mis_cnt}, 32'd3);
    query(PC_A);
    chk("down3_pred", {31'd0, io_takenPre}, 32'd0);

    for (int v = 0; v < 8; v++) begin
      io_pc = vecs[v].pc;
      upd(vecs[v].pc, vecs[v].dir, vecs[v].miss);
    end
    for (int v = 0; v < 8; v++) begin
      query(vecs[v].pc);
      tick();
    end
    chk("mis_vec", {16'd0, bht_mis_cnt}, 32'd6);

    io_takenValid = 1'b1;
    io_takenMiss  = 1'b1;
    io_takenPC    = PC_A;
    io_exTakenPre = 1'b1;
    do_reset(2);
    repeat (50) tick();
    do_reset(1);
    repeat (100) tick();
    chk("init_mis", {16'd0, bht_mis_cnt}, 32'd0);
    io_takenValid = 1'b0;
    io_takenMiss  = 1'b0;
    wait_ready(n);
    chk("reinit_len", n + 100, 32'd128);
    query(PC_A);
    chk("reinit_pred", {31'd0, io_takenPre}, 32'd0);
    tick();
    chk("reinit_mis", {16'd0, bht_mis_cnt}, 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
